// File: rtl/multicycle_adder.sv
// Purpose : unsigned WIDTH-bit adder that adds CHUNK bits per clock (a + b + c_in).
// Latency : out_valid rises NCHUNK edges after the accepting edge; one operation at a time.
// Backpr. : in_ready only in IDLE; the result is held in DONE until out_ready is seen.
//
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   in_valid / in_ready  operand handshake for a, b, c_in
//   out_valid / out_ready result handshake for sum, c_out (and ovf)
//   ovf                  two's-complement overflow, present only when the
//                        macro MULTICYCLE_ADDER_OVF_EN is defined
module multicycle_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
`ifdef MULTICYCLE_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NCHUNK = WIDTH / CHUNK;
  // A single-chunk configuration still needs a 1-bit index register.
  localparam int IDX_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_out_q, c_out_d;
`ifdef MULTICYCLE_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK:0]   chunk_sum;

  // Slice of the captured operands selected by the current chunk index.
  always_comb begin
    a_chunk   = a_q[int'(idx_q)*CHUNK +: CHUNK];
    b_chunk   = b_q[int'(idx_q)*CHUNK +: CHUNK];
    chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    idx_d     = idx_q;
    carry_d   = carry_q;
    sum_d     = sum_q;
    c_out_d   = c_out_q;
`ifdef MULTICYCLE_ADDER_OVF_EN
    ovf_d     = ovf_q;
`endif
    in_ready  = 1'b0;
    out_valid = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = c_in;
          idx_d   = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        sum_d[int'(idx_q)*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
        carry_d = chunk_sum[CHUNK];
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          c_out_d = chunk_sum[CHUNK];
`ifdef MULTICYCLE_ADDER_OVF_EN
          // Carry into the MSB is recovered as a^b^sum at that bit; overflow
          // is that carry differing from the carry out of the MSB.
          ovf_d   = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ chunk_sum[CHUNK-1] ^ chunk_sum[CHUNK];
`endif
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
`ifdef MULTICYCLE_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
`ifdef MULTICYCLE_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign sum   = sum_q;
  assign c_out = c_out_q;
`ifdef MULTICYCLE_ADDER_OVF_EN
  assign ovf   = ovf_q;
`endif

endmodule
